// File: rtl/decode_stage.sv
// decode_stage: instruction decode for a two-opcode (li / addi) pipeline.
// Holds the 8x8 register file with write-through reads from writeback and
// loads the ID_EX pipeline register one edge after an instruction is accepted.
//
// Optional feature: define DECODE_STAGE_FORWARD_EN to resolve RAW hazards by
// forwarding i_ex_result. Without it, a hazard stalls fetch for one cycle and
// a bubble is inserted; the producer then reaches writeback and the
// write-through path supplies its value.
module decode_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_instr_valid,
  input  logic [15:0] i_instr,
  output logic        o_instr_ready,
  input  logic        i_wb_regwrite,
  input  logic [2:0]  i_wb_rd,
  input  logic [7:0]  i_wb_data,
  input  logic [7:0]  i_ex_result,
  output logic        o_id_ex_valid,
  output logic        o_id_ex_alusrc,
  output logic [7:0]  o_id_ex_read_data,
  output logic [7:0]  o_id_ex_imm_data,
  output logic [2:0]  o_id_ex_rd,
  output logic        o_id_ex_regwrite
);

  localparam logic [3:0] OP_LI   = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;

  logic [7:0] r_regs [8];

  logic       r_id_ex_valid;
  logic       r_id_ex_alusrc;
  logic [7:0] r_id_ex_read_data;
  logic [7:0] r_id_ex_imm_data;
  logic [2:0] r_id_ex_rd;
  logic       r_id_ex_regwrite;

  logic [3:0] w_opcode;
  logic [2:0] w_rs;
  logic [7:0] w_imm;
  logic       w_is_li;
  logic       w_is_addi;
  logic       w_hazard;
  logic       w_wb_bypass;
  logic       w_instr_ready;
  logic       w_accept;
  logic [7:0] w_read_data;
  logic       w_unused_inputs;

  logic       w_nxt_valid;
  logic       w_nxt_alusrc;
  logic [7:0] w_nxt_read_data;
  logic [7:0] w_nxt_imm_data;
  logic [2:0] w_nxt_rd;
  logic       w_nxt_regwrite;

  assign w_opcode  = i_instr[15:12];
  assign w_rs      = i_instr[11:9];
  assign w_imm     = i_instr[7:0];
  assign w_is_li   = (w_opcode == OP_LI);
  assign w_is_addi = (w_opcode == OP_ADDI);

  // li has no source operand, so only addi can depend on the instruction in ID_EX.
  assign w_hazard = i_instr_valid && w_is_addi && r_id_ex_valid &&
                    r_id_ex_regwrite && (r_id_ex_rd == w_rs);

  assign w_wb_bypass = i_wb_regwrite && (i_wb_rd == w_rs);

`ifdef DECODE_STAGE_FORWARD_EN
  assign w_instr_ready   = !i_reset;
  assign w_unused_inputs = i_instr[8];

  // Operand read: EX forward beats writeback bypass beats the array.
  always_comb begin
    if (w_hazard)
      w_read_data = i_ex_result;
    else if (w_wb_bypass)
      w_read_data = i_wb_data;
    else
      w_read_data = r_regs[w_rs];
  end
`else
  assign w_instr_ready   = !i_reset && !w_hazard;
  assign w_unused_inputs = i_instr[8] ^ (^i_ex_result);

  // Operand read: writeback bypass beats the array.
  always_comb begin
    if (w_wb_bypass)
      w_read_data = i_wb_data;
    else
      w_read_data = r_regs[w_rs];
  end
`endif

  assign w_accept      = i_instr_valid && w_instr_ready;
  assign o_instr_ready = w_instr_ready;

  // Next ID_EX contents: decoded instruction when accepted, otherwise a bubble.
  always_comb begin
    w_nxt_valid     = 1'b0;
    w_nxt_alusrc    = 1'b0;
    w_nxt_read_data = 8'h00;
    w_nxt_imm_data  = 8'h00;
    w_nxt_rd        = 3'd0;
    w_nxt_regwrite  = 1'b0;
    if (w_accept) begin
      w_nxt_valid = 1'b1;
      if (w_is_li) begin
        w_nxt_imm_data = w_imm;
        w_nxt_rd       = w_rs;
        w_nxt_regwrite = 1'b1;
      end else if (w_is_addi) begin
        w_nxt_alusrc    = 1'b1;
        w_nxt_read_data = w_read_data;
        w_nxt_imm_data  = w_imm;
        w_nxt_rd        = w_rs;
        w_nxt_regwrite  = 1'b1;
      end
    end
  end

  // ID_EX pipeline register; reset also drops any stalled instruction.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_id_ex_valid     <= 1'b0;
      r_id_ex_alusrc    <= 1'b0;
      r_id_ex_read_data <= 8'h00;
      r_id_ex_imm_data  <= 8'h00;
      r_id_ex_rd        <= 3'd0;
      r_id_ex_regwrite  <= 1'b0;
    end else begin
      r_id_ex_valid     <= w_nxt_valid;
      r_id_ex_alusrc    <= w_nxt_alusrc;
      r_id_ex_read_data <= w_nxt_read_data;
      r_id_ex_imm_data  <= w_nxt_imm_data;
      r_id_ex_rd        <= w_nxt_rd;
      r_id_ex_regwrite  <= w_nxt_regwrite;
    end
  end

  // Register file; a writeback coinciding with reset is discarded.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
    end else if (i_wb_regwrite) begin
      r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  assign o_id_ex_valid     = r_id_ex_valid;
  assign o_id_ex_alusrc    = r_id_ex_alusrc;
  assign o_id_ex_read_data = r_id_ex_read_data;
  assign o_id_ex_imm_data  = r_id_ex_imm_data;
  assign o_id_ex_rd        = r_id_ex_rd;
  assign o_id_ex_regwrite  = r_id_ex_regwrite;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: vector table plus a reset-during-stall sequence.
// Expected ID_EX contents are queued when stimulus is driven and compared one
// edge later; Instr_Ready is compared combinationally before each edge.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        wb_regwrite;
  logic [2:0]  wb_rd;
  logic [7:0]  wb_data;
  logic [7:0]  ex_result;
  logic        id_ex_valid;
  logic        id_ex_alusrc;
  logic [7:0]  id_ex_read_data;
  logic [7:0]  id_ex_imm_data;
  logic [2:0]  id_ex_rd;
  logic        id_ex_regwrite;

  decode_stage dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_instr_valid     (instr_valid),
    .i_instr           (instr),
    .o_instr_ready     (instr_ready),
    .i_wb_regwrite     (wb_regwrite),
    .i_wb_rd           (wb_rd),
    .i_wb_data         (wb_data),
    .i_ex_result       (ex_result),
    .o_id_ex_valid     (id_ex_valid),
    .o_id_ex_alusrc    (id_ex_alusrc),
    .o_id_ex_read_data (id_ex_read_data),
    .o_id_ex_imm_data  (id_ex_imm_data),
    .o_id_ex_rd        (id_ex_rd),
    .o_id_ex_regwrite  (id_ex_regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {valid, alusrc, read_data, imm_data, rd, regwrite}
  typedef struct packed {
    logic       valid;
    logic       alusrc;
    logic [7:0] read_data;
    logic [7:0] imm_data;
    logic [2:0] rd;
    logic       regwrite;
  } out_t;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [15:0] ins;
    logic        wbw;
    logic [2:0]  wbrd;
    logic [7:0]  wbd;
    logic [7:0]  exr;
    logic        exp_ready;
    out_t        exp_out;
  } vec_t;

  localparam int NV = 13;
  localparam int NH = 5;
  vec_t vec [NV];
  vec_t hseq [NH];
  out_t exp_q [$];

  int checks = 0;
  int errors = 0;

  function automatic out_t mk(input logic v, input logic a, input logic [7:0] rdat,
                              input logic [7:0] imm, input logic [2:0] rd,
                              input logic rw);
    out_t o;
    o.valid = v; o.alusrc = a; o.read_data = rdat;
    o.imm_data = imm; o.rd = rd; o.regwrite = rw;
    return o;
  endfunction

  function automatic vec_t mv(input logic rst, input logic iv, input logic [15:0] ins,
                              input logic wbw, input logic [2:0] wbrd,
                              input logic [7:0] wbd, input logic [7:0] exr,
                              input logic rdy, input out_t eo);
    vec_t t;
    t.rst = rst; t.iv = iv; t.ins = ins; t.wbw = wbw; t.wbrd = wbrd;
    t.wbd = wbd; t.exr = exr; t.exp_ready = rdy; t.exp_out = eo;
    return t;
  endfunction

  task automatic apply(input vec_t t, input string name);
    out_t got;
    out_t want;
    @(negedge clk);
    reset       = t.rst;
    instr_valid = t.iv;
    instr       = t.ins;
    wb_regwrite = t.wbw;
    wb_rd       = t.wbrd;
    wb_data     = t.wbd;
    ex_result   = t.exr;
    exp_q.push_back(t.exp_out);
    #1;
    checks++;
    if (instr_ready !== t.exp_ready) begin
      errors++;
      $display("FAIL %s ready: got %b expected %b", name, instr_ready, t.exp_ready);
    end
    @(posedge clk);
    #1;
    got = {id_ex_valid, id_ex_alusrc, id_ex_read_data, id_ex_imm_data,
           id_ex_rd, id_ex_regwrite};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s id_ex: scoreboard empty, got %h", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        errors++;
        $display("FAIL %s id_ex: got v=%b src=%b rd_data=%h imm=%h rd=%0d rw=%b expected v=%b src=%b rd_data=%h imm=%h rd=%0d rw=%b",
                 name, got.valid, got.alusrc, got.read_data, got.imm_data, got.rd, got.regwrite,
                 want.valid, want.alusrc, want.read_data, want.imm_data, want.rd, want.regwrite);
      end
    end
  endtask

  initial begin
    out_t z;
    z = mk(1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    reset = 1'b1; instr_valid = 1'b0; instr = 16'h0000;
    wb_regwrite = 1'b0; wb_rd = 3'd0; wb_data = 8'h00; ex_result = 8'h00;

    // rst, iv, instr, wbw, wbrd, wbd, exr, ready, expected ID_EX
    vec[0]  = mv(1, 0, 16'h0000, 0, 3'd0, 8'h00, 8'h00, 0, z);
    vec[1]  = mv(0, 1, 16'h0405, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 0, 8'h00, 8'h05, 3'd2, 1));
    vec[2]  = mv(0, 1, 16'h1601, 1, 3'd3, 8'h40, 8'h00, 1, mk(1, 1, 8'h40, 8'h01, 3'd3, 1));
    vec[3]  = mv(0, 1, 16'h0210, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 0, 8'h00, 8'h10, 3'd1, 1));
`ifdef DECODE_STAGE_FORWARD_EN
    vec[4]  = mv(0, 1, 16'h1202, 0, 3'd0, 8'h00, 8'h10, 1, mk(1, 1, 8'h10, 8'h02, 3'd1, 1));
    vec[5]  = mv(0, 1, 16'h1202, 1, 3'd1, 8'h10, 8'h12, 1, mk(1, 1, 8'h12, 8'h02, 3'd1, 1));
`else
    vec[4]  = mv(0, 1, 16'h1202, 0, 3'd0, 8'h00, 8'h10, 0, z);
    vec[5]  = mv(0, 1, 16'h1202, 1, 3'd1, 8'h10, 8'h12, 1, mk(1, 1, 8'h10, 8'h02, 3'd1, 1));
`endif
    vec[6]  = mv(0, 1, 16'hF3AB, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 0, 8'h00, 8'h00, 3'd0, 0));
    vec[7]  = mv(0, 0, 16'h0405, 0, 3'd0, 8'h00, 8'h00, 1, z);
    vec[8]  = mv(0, 1, 16'h0B7E, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 0, 8'h00, 8'h7E, 3'd5, 1));
    vec[9]  = mv(0, 1, 16'h1103, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 1, 8'h00, 8'h03, 3'd0, 1));
    vec[10] = mv(0, 1, 16'h1605, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 1, 8'h40, 8'h05, 3'd3, 1));
    vec[11] = mv(0, 0, 16'h0000, 1, 3'd7, 8'hFF, 8'h00, 1, z);
    vec[12] = mv(0, 1, 16'h1E00, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 1, 8'hFF, 8'h00, 3'd7, 1));

    // Reset during a stall, with a writeback that must be discarded.
    hseq[0] = mv(0, 1, 16'h0822, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 0, 8'h00, 8'h22, 3'd4, 1));
    hseq[1] = mv(1, 1, 16'h1801, 1, 3'd4, 8'h99, 8'h22, 0, z);
    hseq[2] = mv(0, 1, 16'h1800, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 1, 8'h00, 8'h00, 3'd4, 1));
    hseq[3] = mv(0, 1, 16'h1600, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 1, 8'h00, 8'h00, 3'd3, 1));
    hseq[4] = mv(0, 1, 16'h1E00, 0, 3'd0, 8'h00, 8'h00, 1, mk(1, 1, 8'h00, 8'h00, 3'd7, 1));

    for (int i = 0; i < NV; i++) apply(vec[i], $sformatf("vec%0d", i));
    for (int i = 0; i < NH; i++) apply(hseq[i], $sformatf("rst_stall%0d", i));

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Clk  in  1  sole clock; all state updates on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset, sampled on rising edge of Clk.
REQ-003 Instr_Valid  in  1  upstream fetch presents an instruction this cycle.
REQ-004 Instr  in  16  [15:12] opcode (0000 li, 0001 addi, other = NOP), [11:9] Rd, [8] reserved, [7:0] Imm.
REQ-005 Instr_Ready  out  1  decode accepts Instr this cycle; transfer occurs when Instr_Valid && Instr_Ready.
REQ-006 WB_RegWrite  in  1  writeback stage writes the register file this cycle.
REQ-007 WB_Rd  in  3  writeback destination index.
REQ-008 WB_Data  in  8  writeback data.
REQ-009 EX_Result  in  8  combinational ALU result of the instruction currently held in ID_EX.
REQ-010 ID_EX_Valid  out  1  ID_EX register holds a real instruction (0 = bubble).
REQ-011 ID_EX_ALUSrc  out  1  0 = li (ALU operand1 forced 0), 1 = addi (operand1 = Read_Data).
REQ-012 ID_EX_Read_Data  out  8  register operand for the ALU.
REQ-013 ID_EX_Imm_Data  out  8  immediate for the ALU.
REQ-014 ID_EX_Rd  out  3  destination index passed down the pipe.
REQ-015 ID_EX_RegWrite  out  1  instruction in ID_EX writes a register.

Function
REQ-016 Register file SHALL be 8 entries x 8 bits, all writable, written on Clk edge when WB_RegWrite=1.
REQ-017 Register read SHALL be write-through: if WB_RegWrite && WB_Rd==Instr[11:9], read value = WB_Data same cycle.
REQ-018 On accepted li: ALUSrc=0, Read_Data=0, Imm_Data=Instr[7:0], Rd=Instr[11:9], RegWrite=1, Valid=1 on next edge.
REQ-019 On accepted addi: ALUSrc=1, Read_Data=reg[Instr[11:9]] (with bypass per REQ-017/REQ-021), Imm_Data=Instr[7:0], RegWrite=1, Valid=1.
REQ-020 On accepted NOP opcode: Valid=1, RegWrite=0, ALUSrc=0, Read_Data=0, Imm_Data=0.
REQ-021 RAW hazard SHALL be defined as: Instr_Valid && opcode==addi && ID_EX_Valid && ID_EX_RegWrite && ID_EX_Rd==Instr[11:9].
REQ-022 Hazard bypass priority SHALL be EX_Result (hazard, FORWARD_EN only) over WB_Data (REQ-017) over register array.
REQ-023 When Instr_Valid=0 or Instr_Ready=0, ID_EX SHALL load a bubble: Valid=0, RegWrite=0, other outputs 0.
REQ-024 Instr_Ready SHALL be combinational: 0 during Reset, 0 on hazard when FORWARD_EN undefined, else 1.
REQ-025 A stall SHALL last exactly one cycle: the stalled instruction's producer is then in WB and REQ-017 supplies its value.
REQ-026 li SHALL never cause a hazard; reserved bit [8] SHALL be ignored.
REQ-027 Latency: accepted instruction appears on ID_EX_* exactly one Clk edge after acceptance.

Reset
REQ-028 On Reset=1 at an edge, all ID_EX_* outputs and all 8 registers SHALL become 0; a WB write in the same cycle SHALL be discarded.
REQ-029 Reset mid-stall SHALL drop the stalled instruction; upstream must re-present it.

Configuration
REQ-030 Macro DECODE_STAGE_FORWARD_EN defined: hazards resolved by EX_Result forwarding, Instr_Ready never drops for hazards, no bubbles inserted.
REQ-031 Macro undefined: EX_Result unused, hazards resolved by one-cycle stall and bubble per REQ-024/REQ-025.

Verification
REQ-032 Reset, then li r2,0x05 -> next cycle Valid=1, ALUSrc=0, Read_Data=0x00, Imm=0x05, Rd=2, RegWrite=1.
REQ-033 WB writes r3=0x40 while addi r3,0x01 decoded same cycle -> Read_Data=0x40 (write-through).
REQ-034 FORWARD_EN: li r1,0x10 then addi r1,0x02 back-to-back, EX_Result=0x10 -> Instr_Ready stays 1, addi Read_Data=0x10.
REQ-035 No FORWARD_EN: same sequence -> Instr_Ready=0 one cycle, one bubble (Valid=0), then addi issues with Read_Data=0x10 via WB.
REQ-036 Opcode 0xF with Instr_Valid=1 -> Valid=1, RegWrite=0; Instr_Valid=0 -> Valid=0.
REQ-037 Reset asserted during a stall -> all outputs 0, registers 0 next cycle, Instr_Ready=1 after Reset deasserts.
